audio_dac_serializer: RTL and testbench

AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

---
 rtl/audio_dac_serializer.sv | 125 ++++++++++++
 tb/tb_audio_dac_serializer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_serializer.sv
// Left-justified mono audio DAC serializer: derives bclk/lrclk from clk, shifts
// one FIFO word per frame out MSB first on both channels, mutes on underrun.
module audio_dac_serializer #(
   parameter int DATA_WIDTH = 16,
   parameter int BCLK_HALF  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  en,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  bclk,
   output logic                  lrclk,
   output logic                  dacdat,
   output logic                  underrun,
   output logic [7:0]            underrun_count
);

   localparam int DIV_W = $clog2(BCLK_HALF);
   localparam int CNT_W = $clog2(2 * DATA_WIDTH);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_HALF - 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(2 * DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_RIGHT = CNT_W'(DATA_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      CAPTURE
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [DIV_W-1:0]      div;
   logic [CNT_W-1:0]      bit_cnt;
   logic [CNT_W-1:0]      bit_cnt_next;
   logic                  fe;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] sample_buf;
   logic                  buf_clear;
   logic                  buf_load;

   assign fe           = (div == DIV_LAST) && bclk;
   assign bit_cnt_next = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
   assign dacdat       = shreg[DATA_WIDTH-1];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div  <= '0;
         bclk <= 1'b0;
      end else if (div == DIV_LAST) begin
         div  <= '0;
         bclk <= ~bclk;
      end else begin
         div <= div + DIV_W'(1);
      end
   end

   // Slot starts (left and right) reload the same word, so mono plays on both channels.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bit_cnt <= '0;
         lrclk   <= 1'b1;
         shreg   <= '0;
      end else if (fe) begin
         bit_cnt <= bit_cnt_next;
         lrclk   <= (bit_cnt_next < CNT_RIGHT);
         if ((bit_cnt_next == '0) || (bit_cnt_next == CNT_RIGHT)) begin
            shreg <= sample_buf;
         end else begin
            shreg <= shreg << 1;
         end
      end
   end

   // Fetch starts in the last bit slot; two clk cycles always fit before the next fe.
   always_comb begin
      state_next = state;
      fifo_rd_en = 1'b0;
      underrun   = 1'b0;
      buf_clear  = 1'b0;
      buf_load   = 1'b0;
      case (state)
         IDLE: begin
            if (fe && (bit_cnt_next == CNT_LAST)) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            state_next = IDLE;
            if (en && !fifo_empty) begin
               fifo_rd_en = 1'b1;
               state_next = CAPTURE;
            end else begin
               buf_clear = 1'b1;
               underrun  = en;
            end
         end
         CAPTURE: begin
            buf_load   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= IDLE;
         sample_buf     <= '0;
         underrun_count <= '0;
      end else begin
         state <= state_next;
         if (buf_load) begin
            sample_buf <= fifo_rd_data;
         end else if (buf_clear) begin
            sample_buf <= '0;
         end
         if (underrun && (underrun_count != 8'hFF)) begin
            underrun_count <= underrun_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: directed sequence with random sample words, checked
// against a frame-level model (frame k plays the k-th queued word on both slots).
module tb_audio_dac_serializer;

   localparam int DW    = 16;
   localparam int BH    = 4;
   localparam int FRAME = 2 * DW * 2 * BH;

   typedef struct packed {
      logic [DW-1:0] word;
      logic          lr;
      logic          steady;
   } slot_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          en;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          bclk;
   logic          lrclk;
   logic          dacdat;
   logic          underrun;
   logic [7:0]    underrun_count;
   logic          empty_noise;

   logic          reset2_n;
   logic          rd2, bclk2, lr2, dat2, und2;
   logic [7:0]    cnt2;

   logic [DW-1:0] mem [512];
   int            wr_ptr;
   int            rd_ptr = 0;
   logic          rd_req_seen = 1'b0;
   logic [DW-1:0] pushed[$];

   slot_t         slots[$];
   logic [DW-1:0] shw;
   int            nbits;
   logic          first_lr, steady, prev_bclk;
   int            pops, upulses, rd_empty;
   int            u2_pulses, u2_rd, u2_dat, u2_brise, u2_lrfall;
   logic          prev_bclk2, prev_lr2;

   int            n_pass = 0;
   int            n_total = 0;

   always #5 clk = ~clk;

   audio_dac_serializer #(.DATA_WIDTH(DW), .BCLK_HALF(BH)) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .bclk(bclk),
      .lrclk(lrclk), .dacdat(dacdat), .underrun(underrun),
      .underrun_count(underrun_count)
   );

   // Small-frame instance used to reach counter saturation quickly.
   audio_dac_serializer #(.DATA_WIDTH(2), .BCLK_HALF(2)) dut2 (
      .clk(clk), .reset_n(reset2_n), .en(1'b1), .fifo_empty(1'b1),
      .fifo_rd_en(rd2), .fifo_rd_data(2'b00), .bclk(bclk2),
      .lrclk(lr2), .dacdat(dat2), .underrun(und2), .underrun_count(cnt2)
   );

   assign fifo_empty = (wr_ptr == rd_ptr) ^ empty_noise;

   always @(negedge clk) rd_req_seen <= fifo_rd_en;

   always @(posedge clk) begin
      if (rd_req_seen && (wr_ptr != rd_ptr)) begin
         fifo_rd_data <= mem[rd_ptr % 512];
         rd_ptr       <= rd_ptr + 1;
      end
   end

   // Codec-side receiver: latch dacdat on each bclk rise, 16 bits per slot.
   always @(negedge clk) begin
      if (!reset_n) begin
         slots.delete();
         nbits     <= 0;
         shw       <= '0;
         first_lr  <= 1'b0;
         steady    <= 1'b1;
         prev_bclk <= 1'b0;
         pops      <= 0;
         upulses   <= 0;
         rd_empty  <= 0;
      end else begin
         if (fifo_rd_en) pops <= pops + 1;
         if (fifo_rd_en && fifo_empty) rd_empty <= rd_empty + 1;
         if (underrun) upulses <= upulses + 1;
         if (bclk && !prev_bclk) begin
            if (nbits == DW - 1) begin
               slots.push_back('{word: {shw[DW-2:0], dacdat}, lr: first_lr,
                                 steady: steady && (lrclk == first_lr)});
               nbits  <= 0;
               steady <= 1'b1;
            end else begin
               if (nbits == 0) first_lr <= lrclk;
               else if (lrclk != first_lr) steady <= 1'b0;
               shw   <= {shw[DW-2:0], dacdat};
               nbits <= nbits + 1;
            end
         end
         prev_bclk <= bclk;
      end
   end

   always @(negedge clk) begin
      if (!reset2_n) begin
         u2_pulses  <= 0;
         u2_rd      <= 0;
         u2_dat     <= 0;
         u2_brise   <= 0;
         u2_lrfall  <= 0;
         prev_bclk2 <= 1'b0;
         prev_lr2   <= 1'b1;
      end else begin
         if (und2) u2_pulses <= u2_pulses + 1;
         if (rd2) u2_rd <= u2_rd + 1;
         if (dat2) u2_dat <= u2_dat + 1;
         if (bclk2 && !prev_bclk2) u2_brise <= u2_brise + 1;
         if (!lr2 && prev_lr2) u2_lrfall <= u2_lrfall + 1;
         prev_bclk2 <= bclk2;
         prev_lr2   <= lr2;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic push(input logic [DW-1:0] w);
      mem[wr_ptr % 512] = w;
      wr_ptr++;
      pushed.push_back(w);
   endtask

   task automatic hold_reset(input bit toggle);
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (toggle) begin
            en          = 1'($urandom);
            empty_noise = 1'($urandom);
         end
         step();
      end
      empty_noise = 1'b0;
      wr_ptr      = rd_ptr;
      pushed.delete();
   endtask

   task automatic run(input int n, output int first_pop);
      first_pop = -1;
      for (int c = 1; c <= n; c++) begin
         step();
         if (fifo_rd_en && (first_pop < 0)) first_pop = c;
      end
   endtask

   task automatic wait_for(input int which, input logic lvl, inout int c);
      int guard = 0;
      while (((which == 0) ? bclk : lrclk) !== lvl && guard < 600) begin
         step();
         c++;
         guard++;
      end
   endtask

   task automatic check_reset_values(input string t);
      chk({t, " bclk"}, 32'(bclk), 32'd0);
      chk({t, " lrclk"}, 32'(lrclk), 32'd1);
      chk({t, " dacdat"}, 32'(dacdat), 32'd0);
      chk({t, " fifo_rd_en"}, 32'(fifo_rd_en), 32'd0);
      chk({t, " underrun"}, 32'(underrun), 32'd0);
      chk({t, " underrun_count"}, 32'(underrun_count), 32'd0);
   endtask

   // Frame 0 after reset is silent; frame k plays the (k-1)-th queued word when enabled.
   task automatic check_frames(input string t, input int nframes);
      logic [DW-1:0] expw;
      for (int f = 0; f < nframes; f++) begin
         expw = (f >= 1 && en && (f - 1) < pushed.size()) ? pushed[f-1] : '0;
         for (int s = 0; s < 2; s++) begin
            if (2 * f + s < slots.size()) begin
               chk($sformatf("%s frame%0d slot%0d data", t, f, s),
                   32'(slots[2*f+s].word), 32'(expw));
               chk($sformatf("%s frame%0d slot%0d lrclk", t, f, s),
                   32'(slots[2*f+s].lr), 32'(s == 0));
               chk($sformatf("%s frame%0d slot%0d lrclk steady", t, f, s),
                   32'(slots[2*f+s].steady), 32'd1);
            end else begin
               chk($sformatf("%s frame%0d slot%0d present", t, f, s),
                   32'(slots.size()), 32'(2 * f + s + 1));
            end
         end
      end
   endtask

   task automatic check_counts(input string t, input int p, input int u);
      chk({t, " pops"}, 32'(pops), 32'(p));
      chk({t, " underrun pulses"}, 32'(upulses), 32'(u));
      chk({t, " underrun_count"}, 32'(underrun_count), 32'(u));
      chk({t, " pop while empty"}, 32'(rd_empty), 32'd0);
   endtask

   initial begin
      int fp, c, rise1, fall1, rise2, lf1, lf2, n;
      reset_n     = 1'b0;
      reset2_n    = 1'b0;
      en          = 1'b0;
      empty_noise = 1'b0;
      wr_ptr      = 0;

      // Reset with toggling inputs, then clock timing.
      hold_reset(1'b1);
      check_reset_values("reset");
      en = 1'b0;
      reset_n = 1'b1;
      c = 0;
      wait_for(0, 1'b1, c); rise1 = c;
      wait_for(0, 1'b0, c); fall1 = c;
      wait_for(0, 1'b1, c); rise2 = c;
      wait_for(1, 1'b0, c); lf1 = c;
      wait_for(1, 1'b1, c);
      wait_for(1, 1'b0, c); lf2 = c;
      chk("first bclk rise", 32'(rise1), 32'(BH));
      chk("first bclk fall", 32'(fall1), 32'(2 * BH));
      chk("bclk period", 32'(rise2 - rise1), 32'(2 * BH));
      chk("lrclk period", 32'(lf2 - lf1), 32'(FRAME));

      // Single preloaded word.
      hold_reset(1'b0);
      push(16'hA5C3);
      en = 1'b1;
      reset_n = 1'b1;
      run(4 * FRAME + 8, fp);
      chk("a5c3 pop in slot 31", 32'((fp >= FRAME - 2 * BH) && (fp < FRAME)), 32'd1);
      check_counts("a5c3", 1, 3);
      check_frames("a5c3", 4);

      // Back-to-back words: MSB and LSB positions.
      hold_reset(1'b0);
      push(16'h8000);
      push(16'h0001);
      en = 1'b1;
      reset_n = 1'b1;
      run(3 * FRAME + 8, fp);
      check_counts("b2b", 2, 1);
      check_frames("b2b", 3);

      // Random words.
      for (int it = 0; it < 2; it++) begin
         hold_reset(1'b0);
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++) push(DW'($urandom_range(0, 65535)));
         en = 1'b1;
         reset_n = 1'b1;
         run((n + 2) * FRAME + 8, fp);
         check_counts($sformatf("rand%0d", it), n, 2);
         check_frames($sformatf("rand%0d", it), n + 2);
      end

      // Empty FIFO while enabled.
      hold_reset(1'b0);
      en = 1'b1;
      reset_n = 1'b1;
      run(3 * FRAME + 8, fp);
      check_counts("empty", 0, 3);
      check_frames("empty", 3);

      // Disabled with data waiting.
      hold_reset(1'b0);
      push(DW'($urandom_range(0, 65535)));
      push(DW'($urandom_range(0, 65535)));
      en = 1'b0;
      reset_n = 1'b1;
      run(4 * FRAME + 8, fp);
      check_counts("disabled", 0, 0);
      check_frames("disabled", 4);
      chk("disabled fifo untouched", 32'(wr_ptr - rd_ptr), 32'd2);

      // Reset pulse while capturing a popped word.
      hold_reset(1'b0);
      push(16'h1234);
      en = 1'b1;
      reset_n = 1'b1;
      c = 0;
      while (!fifo_rd_en && c < FRAME + 16) begin
         step();
         c++;
      end
      chk("capture test pop seen", 32'(fifo_rd_en), 32'd1);
      step();
      reset_n = 1'b0;
      step();
      check_reset_values("mid-capture reset");
      pushed.delete();
      reset_n = 1'b1;
      run(2 * FRAME + 8, fp);
      chk("capture word consumed", 32'(wr_ptr - rd_ptr), 32'd0);
      check_counts("post-capture", 0, 2);
      check_frames("post-capture", 2);

      // Saturation: 16-cycle frames, one underrun per frame.
      reset2_n = 1'b0;
      step();
      step();
      chk("sat count after reset", 32'(cnt2), 32'd0);
      reset2_n = 1'b1;
      for (int k = 0; k < 255 * 16; k++) step();
      chk("sat pulses at 255 frames", 32'(u2_pulses), 32'd255);
      chk("sat count at 255 frames", 32'(cnt2), 32'd255);
      for (int k = 0; k < 45 * 16; k++) step();
      chk("sat pulses at 300 frames", 32'(u2_pulses), 32'd300);
      chk("sat count held", 32'(cnt2), 32'd255);
      chk("sat no pops", 32'(u2_rd), 32'd0);
      chk("sat dacdat silent", 32'(u2_dat), 32'd0);
      chk("sat bclk rises", 32'(u2_brise), 32'd1200);
      chk("sat lrclk falls", 32'(u2_lrfall), 32'd300);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
